// File: rtl/adc_seq_pkg.sv
// adc_seq_pkg: shared state encoding, FIFO word layout and channel helpers for the LTC2308 scan scheduler
package adc_seq_pkg;
    localparam int NUM_CH = 8;
    localparam int CH_W = 3;
    localparam int SAMPLE_W = 12;
    localparam int WORD_W = 16;
    localparam int SAMPLE_LSB = 0;
    localparam int TAG_LSB = 12;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARM   = 3'd1,
        S_START = 3'd2,
        S_CONV  = 3'd3,
        S_STORE = 3'd4
    } sched_state_t;

    typedef struct packed {
        logic            found;
        logic [CH_W-1:0] ch;
    } ch_sel_t;

    // lowest set bit of mask strictly above index after (after = -1 gives the first set bit)
    function automatic ch_sel_t next_ch(input logic [NUM_CH-1:0] mask, input int after);
        next_ch = '0;
        for (int i = NUM_CH - 1; i >= 0; i--)
            if (mask[i] && i > after) next_ch = '{found: 1'b1, ch: CH_W'(i)};
    endfunction

    function automatic logic [WORD_W-1:0] pack_word(input logic [CH_W-1:0] ch, input logic [SAMPLE_W-1:0] sample);
        pack_word = '0;
        pack_word[TAG_LSB +: CH_W] = ch;
        pack_word[SAMPLE_LSB +: SAMPLE_W] = sample;
    endfunction
endpackage

// File: rtl/adc_period_timer.sv
// adc_period_timer: reloading down-counter that emits one scan tick every period+1 cycles while enabled
module adc_period_timer
    import adc_seq_pkg::*;
#(
    parameter int PERIOD_W = 16
) (
    input  logic                adc_clk,
    input  logic                adc_reset,
    input  logic                enable,
    input  logic [PERIOD_W-1:0] period,
    output logic                tick
);
    logic [PERIOD_W-1:0] count;

    assign tick = enable && count == '0;

    always_ff @(posedge adc_clk)
        count <= (adc_reset || !enable || tick) ? period : count - 1'b1;
endmodule

// File: rtl/adc_seq_sched.sv
// adc_seq_sched: periodic LTC2308 channel scanner with one-deep result pipeline and tagged FIFO writes
module adc_seq_sched #(
    parameter int NUM_CH   = adc_seq_pkg::NUM_CH,
    parameter int PERIOD_W = 16
) (
    input  logic                adc_clk,
    input  logic                adc_reset,
    input  logic                enable,
    input  logic [NUM_CH-1:0]   ch_mask,
    input  logic [PERIOD_W-1:0] period,
    input  logic                measure_done,
    input  logic [11:0]         measure_dataread,
    output logic                measure_start,
    output logic [2:0]          measure_ch,
    input  logic                fifo_wrfull,
    output logic                fifo_wrreq,
    output logic [15:0]         fifo_data,
    output logic [15:0]         overflow_count,
    output logic                tick_miss,
    output logic                busy,
    output logic [2:0]          sched_state
);
    import adc_seq_pkg::*;

    sched_state_t      state, next_state;
    logic              tick, launch, settle, priming, last_conv, pending;
    logic              store, store_ok, store_drop;
    logic [NUM_CH-1:0] scan_mask;
    logic [CH_W-1:0]   cur_ch, tag_ch;
    ch_sel_t           arm_sel, wrap_sel, next_sel;

    adc_period_timer #(.PERIOD_W(PERIOD_W)) u_timer (
        .adc_clk  (adc_clk),
        .adc_reset(adc_reset),
        .enable   (enable),
        .period   (period),
        .tick     (tick)
    );

    assign arm_sel    = next_ch(ch_mask, -1);
    assign wrap_sel   = next_ch(scan_mask, -1);
    assign next_sel   = next_ch(scan_mask, int'(cur_ch));
    assign launch     = (tick || (pending && enable)) && ch_mask != '0;
    assign store      = state == S_STORE && !priming;
    assign store_ok   = store && !fifo_wrfull;
    assign store_drop = store && fifo_wrfull;

    assign measure_start = state == S_START;
    assign measure_ch    = cur_ch;
    assign busy          = state != S_IDLE;
    assign sched_state   = state;

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  next_state = launch ? S_ARM : S_IDLE;
            S_ARM:   next_state = S_START;
            S_START: next_state = S_CONV;
            // settle masks the stale done level left over from the previous conversion
            S_CONV:  next_state = (!settle && measure_done) ? S_STORE : S_CONV;
            S_STORE: next_state = (last_conv || !enable) ? S_IDLE : S_START;
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge adc_clk) begin
        if (adc_reset) begin
            state          <= S_IDLE;
            settle         <= 1'b0;
            priming        <= 1'b0;
            last_conv      <= 1'b0;
            pending        <= 1'b0;
            tick_miss      <= 1'b0;
            scan_mask      <= '0;
            cur_ch         <= '0;
            tag_ch         <= '0;
            fifo_wrreq     <= 1'b0;
            fifo_data      <= '0;
            overflow_count <= '0;
        end else begin
            state      <= next_state;
            settle     <= state == S_START;
            fifo_wrreq <= store_ok;
            if (store_ok) fifo_data <= pack_word(tag_ch, measure_dataread);
            if (store_drop && overflow_count != '1) overflow_count <= overflow_count + 1'b1;
            pending <= (!enable || state == S_IDLE) ? 1'b0 : (pending || tick);
            if (tick && pending && state != S_IDLE) tick_miss <= 1'b1;
            if (state == S_ARM) begin
                scan_mask <= ch_mask;
                cur_ch    <= arm_sel.ch;
                priming   <= 1'b1;
                last_conv <= 1'b0;
            end
            // after the last set bit the first channel is re-issued to flush the pipeline
            if (state == S_STORE) begin
                tag_ch    <= cur_ch;
                priming   <= 1'b0;
                cur_ch    <= next_sel.found ? next_sel.ch : wrap_sel.ch;
                last_conv <= !next_sel.found;
            end
        end
    end
endmodule

// File: tb/tb_adc_seq_sched.sv
// tb_adc_seq_sched: directed checks of the scan scheduler against a pipelined LTC2308 responder
module tb_adc_seq_sched;
    logic        adc_clk = 1'b0;
    logic        adc_reset = 1'b1;
    logic        enable = 1'b0;
    logic [7:0]  ch_mask = 8'h00;
    logic [15:0] period = 16'd0;
    logic        measure_done = 1'b0;
    logic [11:0] measure_dataread = 12'h000;
    logic        fifo_wrfull = 1'b0;
    logic        measure_start, fifo_wrreq, tick_miss, busy;
    logic [2:0]  measure_ch, sched_state;
    logic [15:0] fifo_data, overflow_count;

    adc_seq_sched dut (
        .adc_clk         (adc_clk),
        .adc_reset       (adc_reset),
        .enable          (enable),
        .ch_mask         (ch_mask),
        .period          (period),
        .measure_done    (measure_done),
        .measure_dataread(measure_dataread),
        .measure_start   (measure_start),
        .measure_ch      (measure_ch),
        .fifo_wrfull     (fifo_wrfull),
        .fifo_wrreq      (fifo_wrreq),
        .fifo_data       (fifo_data),
        .overflow_count  (overflow_count),
        .tick_miss       (tick_miss),
        .busy            (busy),
        .sched_state     (sched_state)
    );

    always #5 adc_clk = ~adc_clk;

    // converter: done stays high one cycle past start, result returns the previously issued channel
    logic [2:0] issued = 3'd0, prev_ch = 3'd0;
    int         cnt = 0;
    always @(posedge adc_clk) begin
        if (measure_start) begin
            cnt     <= 6;
            prev_ch <= issued;
            issued  <= measure_ch;
        end else if (cnt != 0) begin
            cnt <= cnt - 1;
            if (cnt == 6) measure_done <= 1'b0;
            if (cnt == 1) begin
                measure_done     <= 1'b1;
                measure_dataread <= 12'h500 + 12'(prev_ch);
            end
        end
    end

    int         cyc = 0, starts = 0, writes = 0, busy_cnt = 0;
    logic [2:0] chq[$];
    int         stq[$];
    logic [15:0] wq[$];
    always @(posedge adc_clk) cyc <= cyc + 1;
    always @(negedge adc_clk) begin
        if (measure_start) begin
            starts++;
            chq.push_back(measure_ch);
            stq.push_back(cyc);
        end
        if (fifo_wrreq) begin
            writes++;
            wq.push_back(fifo_data);
        end
        if (busy) busy_cnt++;
    end

    int checks = 0, fails = 0;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge adc_clk);
    endtask

    task automatic wait_busy(input logic lvl, input string tag);
        int k = 0;
        while (busy !== lvl && k < 2000) begin
            @(negedge adc_clk);
            k++;
        end
        if (busy !== lvl) chk(tag, 32'(busy), 32'(lvl));
    endtask

    task automatic wait_start(input logic [2:0] ch, input string tag);
        int k = 0;
        while (!(measure_start && measure_ch == ch) && k < 2000) begin
            @(negedge adc_clk);
            k++;
        end
        if (!(measure_start && measure_ch == ch)) chk(tag, 32'(measure_start), 32'd1);
    endtask

    task automatic do_reset(input logic [15:0] p, input logic [7:0] m, input logic full);
        adc_reset = 1'b1;
        enable = 1'b0;
        period = p;
        ch_mask = m;
        fifo_wrfull = full;
        cycles(2);
        adc_reset = 1'b0;
    endtask

    int s0, w0, c0, q0, t0, b0;
    initial begin
        cycles(3);
        chk("rst_ctl", 32'({sched_state, busy, measure_start, fifo_wrreq, tick_miss, measure_ch}), 32'd0);
        chk("rst_ovf", 32'(overflow_count), 32'd0);
        chk("rst_data", 32'(fifo_data), 32'd0);

        // two-channel scan, free-running period
        ch_mask = 8'h05;
        adc_reset = 1'b0;
        enable = 1'b1;
        s0 = starts; w0 = writes; c0 = chq.size(); q0 = wq.size();
        wait_busy(1'b1, "s38_busy_rise");
        wait_busy(1'b0, "s38_busy_fall");
        enable = 1'b0;
        cycles(20);
        chk("s38_starts", 32'(starts - s0), 32'd3);
        chk("s38_ch_a", 32'(chq[c0]), 32'd0);
        chk("s38_ch_b", 32'(chq[c0 + 1]), 32'd2);
        chk("s38_ch_c", 32'(chq[c0 + 2]), 32'd0);
        chk("s38_writes", 32'(writes - w0), 32'd2);
        chk("s38_word_a", 32'(wq[q0]), 32'h0500);
        chk("s38_word_b", 32'(wq[q0 + 1]), 32'h2502);
        chk("s38_tick_miss", 32'(tick_miss), 32'd1);
        chk("s33_done_in_idle", 32'(sched_state), 32'd0);

        // period 99: scans every 100 cycles, no overlap
        do_reset(16'd99, 8'h01, 1'b0);
        enable = 1'b1;
        t0 = cyc; s0 = starts; c0 = stq.size();
        cycles(320);
        chk("s39_starts", 32'(starts - s0), 32'd6);
        chk("s39_first", 32'(stq[c0] - t0), 32'd101);
        chk("s39_conv_gap", 32'(stq[c0 + 1] - stq[c0]), 32'd9);
        chk("s39_scan_gap", 32'(stq[c0 + 2] - stq[c0]), 32'd100);
        chk("s39_no_miss", 32'(tick_miss), 32'd0);

        // one tick per busy scan only pends
        do_reset(16'd14, 8'h01, 1'b0);
        enable = 1'b1;
        c0 = stq.size();
        cycles(100);
        chk("s39_pend_gap", 32'(stq[c0 + 2] - stq[c0]), 32'd20);
        chk("s39_pend_no_miss", 32'(tick_miss), 32'd0);

        // two ticks inside one scan
        do_reset(16'd4, 8'h01, 1'b0);
        enable = 1'b1;
        cycles(40);
        chk("s39_second_overlap", 32'(tick_miss), 32'd1);

        // FIFO held full
        do_reset(16'd0, 8'hFF, 1'b1);
        enable = 1'b1;
        w0 = writes;
        for (int s = 0; s < 3; s++) begin
            wait_busy(1'b1, "s40_busy_rise");
            wait_busy(1'b0, "s40_busy_fall");
        end
        enable = 1'b0;
        cycles(2);
        chk("s40_overflow", 32'(overflow_count), 32'd24);
        chk("s40_no_write", 32'(writes - w0), 32'd0);
        force dut.overflow_count = 16'hFFFE;
        cycles(1);
        release dut.overflow_count;
        enable = 1'b1;
        wait_busy(1'b1, "s40_sat_rise");
        wait_busy(1'b0, "s40_sat_fall");
        enable = 1'b0;
        cycles(2);
        chk("s40_saturate", 32'(overflow_count), 32'hFFFF);

        // reset during a non-priming conversion
        do_reset(16'd0, 8'h05, 1'b0);
        enable = 1'b1;
        w0 = writes;
        wait_start(3'd2, "s41_start_ch2");
        cycles(1);
        chk("s41_in_conv", 32'(sched_state), 32'd3);
        adc_reset = 1'b1;
        cycles(1);
        chk("s41_idle_ctl", 32'({sched_state, busy, measure_start, fifo_wrreq, tick_miss, measure_ch}), 32'd0);
        chk("s41_data", 32'(fifo_data), 32'd0);
        chk("s41_ovf", 32'(overflow_count), 32'd0);
        enable = 1'b0;
        adc_reset = 1'b0;
        cycles(15);
        chk("s41_no_write", 32'(writes - w0), 32'd0);

        // enable dropped during the third conversion
        do_reset(16'd0, 8'h16, 1'b0);
        enable = 1'b1;
        w0 = writes; q0 = wq.size(); s0 = starts;
        wait_start(3'd4, "s42_start_ch4");
        cycles(1);
        enable = 1'b0;
        cycles(40);
        chk("s42_writes", 32'(writes - w0), 32'd2);
        chk("s42_word_a", 32'(wq[q0]), 32'h1501);
        chk("s42_word_b", 32'(wq[q0 + 1]), 32'h2502);
        chk("s42_starts", 32'(starts - s0), 32'd3);
        chk("s42_idle", 32'(busy), 32'd0);

        // empty mask never scans
        do_reset(16'd0, 8'h00, 1'b0);
        enable = 1'b1;
        s0 = starts; b0 = busy_cnt;
        cycles(1000);
        chk("s43_starts", 32'(starts - s0), 32'd0);
        chk("s43_busy", 32'(busy_cnt - b0), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
